// File: rtl/issue_unit.sv
// Tomasulo issue unit: fetches one instruction at a time, decodes it, renames
// its sources through the register status table and allocates a station.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | post-reset, heads straight to FETCH
// FETCH    | fetch_req high, queue advances on this edge
// WAIT     | queue output settles
// DECODE   | latch instruction, drop illegal opcodes
// DISPATCH | wait for free station and no CDB hazard, then issue
// DONE     | N_INSTR instructions issued, absorbing until reset
module issue_unit #(
  parameter int N_ADD   = 3,
  parameter int N_MUL   = 2,
  parameter int N_INSTR = 7
) (
  input  logic             clock,
  input  logic             reset,
  output logic             fetch_req,
  input  logic             instr_valid,
  input  logic [15:0]      instr_in,
  input  logic [N_ADD-1:0] add_busy,
  input  logic [N_MUL-1:0] mul_busy,
  input  logic             cdb_valid,
  input  logic [2:0]       cdb_tag,
  output logic             issue_valid,
  output logic [2:0]       issue_tag,
  output logic [3:0]       issue_op,
  output logic [2:0]       issue_rx,
  output logic [2:0]       issue_ry,
  output logic [2:0]       issue_rz,
  output logic [2:0]       issue_offset,
  output logic [2:0]       issue_qj,
  output logic [2:0]       issue_qk,
  output logic             illegal,
  output logic [7:0]       issued_count,
  output logic             done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_DECODE   = 3'd3;
  localparam logic [2:0] S_DISPATCH = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]  state;
  logic [15:0] ir;
  logic [2:0]  rst_tab [8];

  logic [3:0] ir_op;
  logic [2:0] ir_rz, ir_rx, ir_ry, ir_off;
  logic       add_class, mul_class;
  logic       found, hazard, can_issue;
  logic [2:0] sel_tag, src_j, src_k;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0100) || (op == 4'b0101);
  endfunction

  assign ir_op  = ir[3:0];
  assign ir_ry  = ir[6:4];
  assign ir_rx  = ir[9:7];
  assign ir_rz  = ir[12:10];
  assign ir_off = ir[15:13];

  assign add_class = (ir_op == 4'b0000) || (ir_op == 4'b0001);
  assign mul_class = (ir_op == 4'b0100) || (ir_op == 4'b0101);

  // Scan downwards so the lowest-numbered free station wins.
  always_comb begin
    found   = 1'b0;
    sel_tag = 3'd0;
    if (add_class) begin
      for (int i = N_ADD - 1; i >= 0; i--) begin
        if (!add_busy[i]) begin
          found   = 1'b1;
          sel_tag = 3'(i + 1);
        end
      end
    end else if (mul_class) begin
      for (int i = N_MUL - 1; i >= 0; i--) begin
        if (!mul_busy[i]) begin
          found   = 1'b1;
          sel_tag = 3'(N_ADD + 1 + i);
        end
      end
    end
  end

  assign src_j = rst_tab[ir_rx];
  assign src_k = rst_tab[ir_ry];

  // A broadcast of a pending source tag holds issue one cycle so qj/qk read 0.
  assign hazard = cdb_valid &&
                  (((src_j != 3'd0) && (cdb_tag == src_j)) ||
                   ((src_k != 3'd0) && (cdb_tag == src_k)));

  assign can_issue = (state == S_DISPATCH) && found && !hazard &&
                     (issued_count < 8'(N_INSTR));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ir           <= '0;
      fetch_req    <= 1'b0;
      issue_valid  <= 1'b0;
      issue_tag    <= '0;
      issue_op     <= '0;
      issue_rx     <= '0;
      issue_ry     <= '0;
      issue_rz     <= '0;
      issue_offset <= '0;
      issue_qj     <= '0;
      issue_qk     <= '0;
      illegal      <= 1'b0;
      issued_count <= '0;
      done         <= 1'b0;
      for (int r = 0; r < 8; r++) rst_tab[r] <= '0;
    end else begin
      fetch_req   <= 1'b0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;

      if (cdb_valid) begin
        for (int r = 0; r < 8; r++) begin
          if (rst_tab[r] == cdb_tag) rst_tab[r] <= 3'd0;
        end
      end

      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          fetch_req <= 1'b1;
        end
        S_FETCH:  state <= S_WAIT;
        S_WAIT:   state <= S_DECODE;
        S_DECODE: begin
          if (!instr_valid) begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
          end else begin
            ir <= instr_in;
            if (!is_legal(instr_in[3:0])) begin
              illegal   <= 1'b1;
              state     <= S_FETCH;
              fetch_req <= 1'b1;
            end else begin
              state <= S_DISPATCH;
            end
          end
        end
        S_DISPATCH: begin
          if (can_issue) begin
            issue_valid  <= 1'b1;
            issue_tag    <= sel_tag;
            issue_op     <= ir_op;
            issue_rx     <= ir_rx;
            issue_ry     <= ir_ry;
            issue_rz     <= ir_rz;
            issue_offset <= ir_off;
            issue_qj     <= src_j;
            issue_qk     <= src_k;
            // Placed after the CDB clear loop so the rename write wins.
            rst_tab[ir_rz] <= sel_tag;
            issued_count   <= issued_count + 8'd1;
            if (issued_count + 8'd1 == 8'(N_INSTR)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              fetch_req <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: queue and station models drive the DUT, a scoreboard
// with a register-status model checks every issue and illegal pulse.
module tb_issue_unit;
  localparam int N_ADD   = 3;
  localparam int N_MUL   = 2;
  localparam int N_INSTR = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             fetch_req;
  logic             instr_valid = 1'b0;
  logic [15:0]      instr_in = '0;
  logic [N_ADD-1:0] add_busy = '0;
  logic [N_MUL-1:0] mul_busy = '0;
  logic             cdb_valid = 1'b0;
  logic [2:0]       cdb_tag = '0;
  logic             issue_valid;
  logic [2:0]       issue_tag, issue_rx, issue_ry, issue_rz, issue_offset, issue_qj, issue_qk;
  logic [3:0]       issue_op;
  logic             illegal;
  logic [7:0]       issued_count;
  logic             done;

  issue_unit #(.N_ADD(N_ADD), .N_MUL(N_MUL), .N_INSTR(N_INSTR)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req),
    .instr_valid(instr_valid), .instr_in(instr_in),
    .add_busy(add_busy), .mul_busy(mul_busy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_op(issue_op),
    .issue_rx(issue_rx), .issue_ry(issue_ry), .issue_rz(issue_rz),
    .issue_offset(issue_offset), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .illegal(illegal), .issued_count(issued_count), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rx, ry, rz, off;
    bit         legal;
  } ins_t;

  ins_t        sb[$];
  logic [15:0] prog[$];
  logic [2:0]  m_rst [8];
  logic [7:0]  st_busy = '0;
  int n_cmp = 0, n_err = 0, cyc = 0, n_issue = 0, n_ill = 0;
  bit release_en = 0, bubble_en = 0;
  int req_complete = 0, comp_cyc = 0;
  int last_tag = 0, last_qj = 0, last_op = 0, last_rz = 0;
  int log_tag[$], log_qj[$], log_qk[$], log_rz[$], log_op[$], log_cyc[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_instr(input logic [3:0] op, input logic [2:0] rz, input logic [2:0] rx,
                            input logic [2:0] ry, input logic [2:0] off);
    ins_t e;
    e.op = op; e.rz = rz; e.rx = rx; e.ry = ry; e.off = off;
    e.legal = (op == 4'd0) || (op == 4'd1) || (op == 4'd4) || (op == 4'd5);
    sb.push_back(e);
    prog.push_back({off, rz, rx, ry, op});
  endtask

  // Station and instruction-queue environment; drives just after the falling edge.
  always @(negedge clock) begin : env
    int t;
    #1;
    cdb_valid = 1'b0;
    cdb_tag   = 3'd0;
    if (issue_valid) st_busy[issue_tag] = 1'b1;
    if (req_complete != 0) begin
      t = req_complete;
      req_complete = 0;
      cdb_valid = 1'b1; cdb_tag = 3'(t); st_busy[t] = 1'b0; comp_cyc = cyc;
    end else if (release_en && $urandom_range(0, 2) == 0) begin
      t = $urandom_range(1, N_ADD + N_MUL);
      if (st_busy[t]) begin
        cdb_valid = 1'b1; cdb_tag = 3'(t); st_busy[t] = 1'b0;
      end
    end
    add_busy = st_busy[N_ADD:1];
    mul_busy = st_busy[N_ADD+N_MUL:N_ADD+1];
    if (fetch_req) begin
      if (prog.size() == 0 || (bubble_en && $urandom_range(0, 7) == 0)) begin
        instr_valid = 1'b0;
      end else begin
        instr_in    = prog.pop_front();
        instr_valid = 1'b1;
      end
    end
  end

  // Monitor: outputs and the inputs sampled on the edge just passed are stable here.
  always @(negedge clock) begin : monitor
    int tag, qj, qk;
    bit fnd, hz, ok_issue;
    ins_t e;
    ok_issue = 0;
    tag = 0;
    if (issue_valid) begin
      if (sb.size() == 0 || !sb[0].legal) begin
        n_cmp++; n_err++;
        $display("FAIL issue_unexpected: got issue tag %0d op %0d, required no issue (cycle %0d)",
                 issue_tag, issue_op, cyc);
      end else begin
        e = sb.pop_front();
        ok_issue = 1;
        fnd = 0;
        if (e.op <= 4'd1) begin
          for (int t = 1; t <= N_ADD; t++)
            if (!fnd && !add_busy[t-1]) begin fnd = 1; tag = t; end
        end else begin
          for (int t = 1; t <= N_MUL; t++)
            if (!fnd && !mul_busy[t-1]) begin fnd = 1; tag = N_ADD + t; end
        end
        qj = m_rst[e.rx];
        qk = m_rst[e.ry];
        hz = cdb_valid && cdb_tag != 3'd0 && (cdb_tag == qj || cdb_tag == qk);
        chk("free_station", fnd, 1);
        chk("no_cdb_hazard", hz, 0);
        chk("tag", issue_tag, tag);
        chk("op", issue_op, e.op);
        chk("rx", issue_rx, e.rx);
        chk("ry", issue_ry, e.ry);
        chk("rz", issue_rz, e.rz);
        chk("offset", issue_offset, e.off);
        chk("qj", issue_qj, qj);
        chk("qk", issue_qk, qk);
        n_issue++;
        log_tag.push_back(issue_tag); log_qj.push_back(issue_qj); log_qk.push_back(issue_qk);
        log_rz.push_back(issue_rz); log_op.push_back(issue_op); log_cyc.push_back(cyc);
        last_tag = issue_tag; last_qj = issue_qj; last_op = issue_op; last_rz = issue_rz;
      end
    end else begin
      chk("hold_tag", issue_tag, last_tag);
      chk("hold_qj", issue_qj, last_qj);
      chk("hold_op", issue_op, last_op);
      chk("hold_rz", issue_rz, last_rz);
    end
    chk("issued_count", issued_count, n_issue);
    chk("done", done, (n_issue == N_INSTR) ? 1 : 0);
    if (done) chk("done_no_fetch", fetch_req, 0);
    if (cdb_valid)
      for (int r = 0; r < 8; r++) if (m_rst[r] == cdb_tag) m_rst[r] = 3'd0;
    if (ok_issue) m_rst[e.rz] = 3'(tag);
    if (illegal) begin
      n_cmp++;
      if (sb.size() > 0 && !sb[0].legal) begin
        void'(sb.pop_front());
        n_ill++;
      end else begin
        n_err++;
        $display("FAIL illegal_unexpected: got illegal pulse, required none (cycle %0d)", cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock); #2;
    reset = 1'b1; release_en = 0; bubble_en = 0; req_complete = 0;
    prog.delete(); sb.delete();
    st_busy = '0;
    for (int r = 0; r < 8; r++) m_rst[r] = 3'd0;
    n_issue = 0; n_ill = 0;
    last_tag = 0; last_qj = 0; last_op = 0; last_rz = 0;
    log_tag.delete(); log_qj.delete(); log_qk.delete();
    log_rz.delete(); log_op.delete(); log_cyc.delete();
    instr_valid = 1'b0; instr_in = '0; add_busy = '0; mul_busy = '0;
    cdb_valid = 1'b0; cdb_tag = '0;
    @(negedge clock); #3;
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_done", done, 0);
    chk("rst_issued_count", issued_count, 0);
    chk("rst_fields", {issue_tag, issue_op, issue_rx, issue_ry, issue_rz, issue_offset,
                       issue_qj, issue_qk}, 0);
    reset = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, input string nm);
    int k = 0;
    while (n_issue < n && k < budget) begin @(negedge clock); #3; k++; end
    chk(nm, n_issue, n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(negedge clock); #3; end
  endtask

  initial begin : main
    for (int r = 0; r < 8; r++) m_rst[r] = 3'd0;
    do_reset();

    // ADD R3,R1,R2 ; SUB R5,R3,R1 ; ADD R5,R4,R6 ; MUL R6,R5,R4
    push_instr(4'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    push_instr(4'd1, 3'd5, 3'd3, 3'd1, 3'd1);
    push_instr(4'd0, 3'd5, 3'd4, 3'd6, 3'd2);
    push_instr(4'd4, 3'd6, 3'd5, 3'd4, 3'd3);
    wait_issues(4, 100, "seq_issues");
    if (log_tag.size() >= 4) begin
      chk("i1_tag", log_tag[0], 1); chk("i1_op", log_op[0], 0);
      chk("i1_qj", log_qj[0], 0);   chk("i1_qk", log_qk[0], 0); chk("i1_rz", log_rz[0], 3);
      chk("i2_tag", log_tag[1], 2); chk("i2_op", log_op[1], 1);
      chk("i2_qj", log_qj[1], 1);   chk("i2_qk", log_qk[1], 0); chk("i2_rz", log_rz[1], 5);
      chk("i3_tag", log_tag[2], 3);
      chk("i4_tag", log_tag[3], 4); chk("i4_qj", log_qj[3], 3); chk("i4_qk", log_qk[3], 0);
      chk("spacing_12", log_cyc[1] - log_cyc[0], 4);
      chk("spacing_23", log_cyc[2] - log_cyc[1], 4);
      chk("spacing_34", log_cyc[3] - log_cyc[2], 4);
    end

    // All add stations busy: ADD must stall until tag 2 frees.
    push_instr(4'd0, 3'd2, 3'd0, 3'd1, 3'd0);
    wait_cycles(16);
    chk("stall_no_issue", n_issue, 4);
    req_complete = 2;
    wait_issues(5, 20, "stall_release");
    if (log_tag.size() >= 5) begin
      chk("release_tag", log_tag[4], 2);
      chk("release_latency", log_cyc[4] - comp_cyc, 1);
    end

    // Reset while stalled in DISPATCH with R6 renamed to tag 4.
    push_instr(4'd0, 3'd1, 3'd6, 3'd0, 3'd0);
    wait_cycles(12);
    chk("stall2_no_issue", n_issue, 5);
    do_reset();
    push_instr(4'd0, 3'd1, 3'd6, 3'd6, 3'd0);
    wait_issues(1, 40, "post_reset_issue");
    if (log_tag.size() >= 1) begin
      chk("post_reset_qj", log_qj[0], 0);
      chk("post_reset_qk", log_qk[0], 0);
      chk("post_reset_tag", log_tag[0], 1);
    end

    // Illegal opcode is dropped without counting.
    do_reset();
    push_instr(4'd15, 3'd2, 3'd1, 3'd1, 3'd0);
    push_instr(4'd1, 3'd2, 3'd3, 3'd3, 3'd0);
    wait_issues(1, 40, "after_illegal_issue");
    chk("illegal_count", n_ill, 1);

    // Randomized episodes run to DONE.
    for (int ep = 0; ep < 16; ep++) begin
      int legal_n;
      int k;
      do_reset();
      release_en = 1; bubble_en = 1;
      legal_n = 0;
      while (legal_n < N_INSTR) begin
        logic [3:0] op;
        if ($urandom_range(0, 4) == 0) begin
          op = 4'($urandom_range(6, 15));
        end else begin
          case ($urandom_range(0, 3))
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd4;
            default: op = 4'd5;
          endcase
          legal_n++;
        end
        push_instr(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      end
      k = 0;
      while (!done && k < 3000) begin @(negedge clock); #3; k++; end
      chk("ep_done", done, 1);
      chk("ep_issues", n_issue, N_INSTR);
      chk("ep_all_consumed", sb.size(), 0);
      wait_cycles(6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

Issue controller between the instruction queue and the reservation stations of the Tomasulo core. It pulls one 16-bit instruction at a time from the queue and decodes it. It allocates a free add/sub or mul reservation station and renames source and destination registers through an internal register status table (RST). The RST is cleared by common data bus (CDB) broadcasts. Issue is strictly in order, one instruction per issue pulse, and it stalls while no station of the required class is free.

## Interface

Parameters:
- N_ADD, 3, number of add/sub reservation stations
- N_MUL, 2, number of mul stations; N_ADD+N_MUL ≤ 7
- N_INSTR, 7, number of instructions to issue before entering DONE

Ports:
- clock  in  1  single clock, all state changes on posedge
- reset  in  1  synchronous, active-high
- fetch_req  out  1  one-cycle request to the queue (drives its disponibilidade)
- instr_valid  in  1  queue output valid (its outLiberado)
- instr_in  in  16  {offset[15:13], Rz[12:10], Rx[9:7], Ry[6:4], opcode[3:0]}
- add_busy  in  N_ADD  busy bit per add station, bit i = tag i+1
- mul_busy  in  N_MUL  busy bit per mul station, bit i = tag N_ADD+1+i
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  3  tag being broadcast
- issue_valid  out  1  one-cycle issue strobe
- issue_tag  out  3  allocated station tag (1..N_ADD+N_MUL)
- issue_op  out  4  opcode
- issue_rx, issue_ry, issue_rz  out  3 each  register indices
- issue_offset  out  3  offset field
- issue_qj, issue_qk  out  3 each  producer tag of Rx/Ry, 0 = value ready in register file
- illegal  out  1  one-cycle pulse when an undecodable opcode is dropped
- issued_count  out  8  instructions issued since reset
- done  out  1  high in DONE

## Operation

- Opcode classes: 4'b0000 ADD and 4'b0001 SUB use the add class. 4'b0100 MUL and 4'b0101 DIV use the mul class. All others are illegal.
- RST: 8 entries of 3 bits, one per R0..R7; 0 means no pending producer.
- FSM states: IDLE, FETCH, WAIT, DECODE, DISPATCH, DONE.
  - IDLE → FETCH unconditionally.
  - FETCH: fetch_req=1 for exactly this cycle → WAIT.
  - WAIT: the queue updates instr_in on this edge → DECODE.
  - DECODE: if instr_valid=0 → FETCH. Otherwise latch instr_in into the internal IR. If the opcode is illegal, pulse illegal, do not count it, and go → FETCH. If legal → DISPATCH.
  - DISPATCH: choose the lowest-numbered free station of the class. Issue when all three conditions hold:
    - a free station exists;
    - no CDB hazard exists (see below);
    - issued_count < N_INSTR.
  - On issue, register all issue_* fields, set issue_valid=1, set RST[Rz]=tag, increment issued_count, and go → FETCH, or → DONE if the new count equals N_INSTR. Otherwise stay in DISPATCH, which is the stall state.
  - DONE: absorbing until reset; done=1.
- issue_qj = RST[Rx] and issue_qk = RST[Ry], sampled in the issue cycle before the Rz update. For example, "ADD R5, R5, R1" gives qj equal to the old producer of R5.
- CDB: on each cycle with cdb_valid, every RST entry equal to cdb_tag is cleared to 0.
- CDB hazard: cdb_valid=1 and cdb_tag equal to a nonzero RST[Rx] or RST[Ry] in DISPATCH. The unit holds for that cycle, and the next cycle issues with qj/qk = 0.
- Simultaneous CDB clear and issue write to RST[Rz]: the issue write wins.
- Reset mid-operation: the FSM returns to IDLE, the RST is zeroed, and any latched instruction is discarded. The queue pointer is not rewound by this block.

## Timing

- Reset values: fetch_req=0, issue_valid=0, illegal=0, done=0, issued_count=0, all issue_* fields 0, RST all 0, state IDLE.
- All outputs are registered; issue_valid and illegal are single-cycle pulses.
- Minimum issue spacing is 4 cycles (FETCH, WAIT, DECODE, DISPATCH). Stations therefore see issue_valid at least 3 cycles before the next allocation, so busy bits are settled.
- issue_* fields hold their values after issue_valid falls until the next issue.
- Busy inputs and the CDB are sampled in DISPATCH on the edge that commits the issue.

## Test plan

- Reset, then queue program ADD R3,R1,R2; SUB R5,R3,R1 with no CDB traffic → issue #1: tag=1, op=0, qj=0, qk=0, rz=3. Issue #2: tag=2, op=1, qj=1, qk=0, rz=5. Spacing is 4 cycles.
- Continue with ADD R5,R4,R6; MUL R6,R5,R4 → ADD gets tag=3. MUL gets tag=4, qj=3 (R5 renamed, WAW over tag 2), qk=0.
- Hold add_busy=3'b111 while an ADD is pending → no issue_valid and the unit stays in DISPATCH. Release bit 1 → issue with tag=2 on the next edge.
- With RST[R3]=1, pulse cdb_valid, cdb_tag=1 in the same cycle the SUB R5,R3,R1 is eligible → hold one cycle, then issue with qj=0. RST[R3] reads 0 afterwards.
- Feed opcode 4'b1111 → one illegal pulse, no issue, issued_count unchanged, next fetch_req 1 cycle later.
- Assert reset while in DISPATCH with RST[R6]=4 → next cycle all outputs 0, RST zeroed. After N_INSTR=7 issues, done=1 and fetch_req stays 0.
